// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the instruction-prefetch path.
package cpu_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          PC_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } pf_state_t;
endpackage

// File: rtl/imem_prefetch_if.sv
// Fetch-stage and instruction-memory signals of the prefetch buffer.
interface imem_prefetch_if #(
  parameter int WIDTH    = 32,
  parameter int INST_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic                cpu_req;
  logic [WIDTH-1:0]    cpu_pc;
  logic [INST_LEN-1:0] inst_o;
  logic                inst_valid_o;
  logic                mem_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_ack;
  logic [INST_LEN-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_pc, mem_ack, mem_rdata,
    output inst_o, inst_valid_o, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_pc, mem_ack, mem_rdata,
    input  inst_o, inst_valid_o, mem_req, mem_addr
  );
endinterface

// File: rtl/imem_prefetch_sync_fifo.sv
// Small synchronous FIFO; head entry is read straight from the storage array.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = wdata;
        tail_d        = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      // simultaneous push and pop leaves the occupancy unchanged
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[head_q];
  assign count = cnt_q;
endmodule

// File: rtl/imem_prefetch.sv
// Instruction prefetch buffer: runs ahead of fetch, serves hits from a FIFO,
// flushes and restarts on a PC redirect.
module imem_prefetch
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               INST_LEN = 32,
  parameter int               ADDR_LEN = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  imem_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);

  pf_state_t           state_q, state_d;
  logic [WIDTH-1:0]    exp_pc_q, exp_pc_d;
  logic [WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]       count;
  logic [INST_LEN-1:0] head_data;
  logic                hit, redir, push;

  always_comb begin
    hit        = bus.cpu_req && (count != '0) && (bus.cpu_pc == exp_pc_q);
    redir      = bus.cpu_req && (bus.cpu_pc != exp_pc_q);
    push       = 1'b0;
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    exp_pc_d   = exp_pc_q;
    fetch_pc_d = fetch_pc_q;

    case (state_q)
      IDLE: begin
        // nothing is in flight here, so count alone bounds the FIFO fill
        if (count < CW'(DEPTH) && !redir) begin
          mem_req_d  = 1'b1;
          mem_addr_d = ADDR_LEN'(fetch_pc_q & ~WIDTH'(3));
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          push      = !redir;
          state_d   = IDLE;
        end else if (redir) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redir) begin
      exp_pc_d   = bus.cpu_pc;
      fetch_pc_d = bus.cpu_pc;
    end else begin
      if (hit)  exp_pc_d   = exp_pc_q + WIDTH'(PC_STEP);
      if (push) fetch_pc_d = fetch_pc_q + WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      exp_pc_q   <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      exp_pc_q   <= exp_pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(INST_LEN)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (hit),
    .flush (redir),
    .wdata (bus.mem_rdata),
    .rdata (head_data),
    .count (count)
  );

  assign bus.inst_valid_o = hit;
  assign bus.inst_o       = hit ? head_data : INST_LEN'(NOP_INST);
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: cycle-level queue model plus a latency-randomised memory.
module tb_imem_prefetch;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_prefetch_if #(.WIDTH(32), .INST_LEN(32), .ADDR_LEN(32)) bus ();

  imem_prefetch #(
    .WIDTH(32), .INST_LEN(32), .ADDR_LEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // reference state: words ready for fetch, expected/next-fetch PCs, outstanding read
  logic [31:0] m_q[$];
  logic [31:0] m_exp = '0, m_fetch = '0, m_addr = '0;
  bit          m_out = 0, m_stale = 0, m_hit, m_redir;

  bit          rst_cmd = 1, rbusy = 0, force_ack = 0, redir_on_ack = 0;
  int          rwait = 0, lat_min = 2, lat_max = 2;
  logic [31:0] redir_pc;
  logic [31:0] reqlog[$], vlog[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h100 + a;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step(input bit req, input logic [31:0] pc);
    logic [31:0] e_inst;
    bit issue;
    @(negedge clk);
    reset         = rst_cmd;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    if (!reset) begin
      if (rbusy) begin
        rwait--;
        if (rwait <= 0) begin bus.mem_ack = 1'b1; rbusy = 0; end
      end else if (bus.mem_req) begin
        reqlog.push_back(bus.mem_addr);
        rwait = $urandom_range(lat_max, lat_min);
        if (rwait == 0) bus.mem_ack = 1'b1;
        else rbusy = 1;
      end
      if (force_ack) begin bus.mem_ack = 1'b1; force_ack = 0; end
    end
    if (bus.mem_ack) bus.mem_rdata = memf(bus.mem_addr);
    bus.cpu_req = req;
    bus.cpu_pc  = pc;
    if (redir_on_ack && bus.mem_ack) begin
      bus.cpu_req  = 1'b1;
      bus.cpu_pc   = redir_pc;
      redir_on_ack = 0;
      reqlog.delete();
    end
    #1;
    m_hit   = bus.cpu_req && m_q.size() != 0 && bus.cpu_pc == m_exp;
    m_redir = bus.cpu_req && bus.cpu_pc != m_exp;
    e_inst  = m_hit ? m_q[0] : NOP_INST;
    chk("inst_valid", 32'(bus.inst_valid_o), 32'(m_hit));
    chk("inst_o", bus.inst_o, e_inst);
    chk("mem_req", 32'(bus.mem_req), 32'(m_out));
    chk("mem_addr", bus.mem_addr, m_addr);
    if (bus.inst_valid_o) vlog.push_back(bus.inst_o);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_exp = '0; m_fetch = '0; m_addr = '0; m_out = 0; m_stale = 0;
    end else begin
      issue = !m_out && m_q.size() < DEPTH && !m_redir;
      if (m_out && bus.mem_ack) begin
        if (!m_stale && !m_redir) begin
          m_q.push_back(bus.mem_rdata);
          m_fetch += 4;
        end
        m_out = 0;
      end else if (m_out && m_redir) begin
        m_stale = 1;
      end
      if (m_hit) begin void'(m_q.pop_front()); m_exp += 4; end
      if (m_redir) begin m_q.delete(); m_exp = bus.cpu_pc; m_fetch = bus.cpu_pc; end
      if (issue) begin m_out = 1; m_stale = 0; m_addr = m_fetch & ~32'h3; end
    end
  endtask

  task automatic do_reset();
    rst_cmd = 1; rbusy = 0; force_ack = 0; redir_on_ack = 0;
    step(0, 0);
    step(0, 0);
    rst_cmd = 0;
    reqlog.delete();
    vlog.delete();
  endtask

  task automatic run_until_valid(input int n, input int bound);
    for (int i = 0; i < bound && vlog.size() < n; i++) step(1, m_exp);
  endtask

  initial begin
    int first;
    bus.cpu_req = 0; bus.cpu_pc = '0; bus.mem_ack = 0; bus.mem_rdata = '0;

    // sequential fetch from reset, ack latency 2
    do_reset();
    first = -1;
    for (int i = 0; i < 40 && vlog.size() < 3; i++) begin
      step(1, m_exp);
      if (vlog.size() == 1 && first < 0) first = i;
    end
    chk("first_valid_cycle", 32'(first), 32'd4);
    for (int i = 0; i < 3; i++) chk("seq_data", qget(vlog, i), 32'h100 + 32'(4 * i));

    // idle prefetch fills exactly DEPTH entries, then drains back to back
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0);
    chk("fill_req_count", 32'(reqlog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) chk("fill_req_addr", qget(reqlog, i), 32'(4 * i));
    vlog.delete();
    for (int i = 0; i < DEPTH; i++) step(1, m_exp);
    chk("drain_count", 32'(vlog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) chk("drain_data", qget(vlog, i), 32'h100 + 32'(4 * i));

    // redirect with a full FIFO
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0);
    vlog.delete();
    step(1, 32'h40);
    chk("redir_no_valid", 32'(vlog.size()), 32'd0);
    reqlog.delete();
    run_until_valid(1, 30);
    chk("redir_req_addr", qget(reqlog, 0), 32'h40);
    chk("redir_data", qget(vlog, 0), 32'h140);

    // redirect while the read for 0x10 is outstanding
    do_reset();
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 40; i++) step(0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, m_exp);
    step(1, 32'h80);
    reqlog.delete();
    vlog.delete();
    run_until_valid(2, 60);
    chk("drop_req_addr", qget(reqlog, 0), 32'h80);
    chk("drop_data0", qget(vlog, 0), 32'h180);
    chk("drop_data1", qget(vlog, 1), 32'h184);

    // redirect in the same cycle as the ack
    do_reset();
    lat_min = 2; lat_max = 2;
    redir_pc = 32'h200; redir_on_ack = 1;
    for (int i = 0; i < 20 && redir_on_ack; i++) step(0, 0);
    vlog.delete();
    run_until_valid(1, 30);
    chk("ackredir_req_addr", qget(reqlog, 0), 32'h200);
    chk("ackredir_data", qget(vlog, 0), 32'h300);

    // PC wraps from 0xFFFF_FFFC to 0
    do_reset();
    step(1, 32'hFFFF_FFF8);
    run_until_valid(3, 60);
    chk("wrap_data0", qget(vlog, 0), 32'h0F8);
    chk("wrap_data1", qget(vlog, 1), 32'h0FC);
    chk("wrap_data2", qget(vlog, 2), 32'h100);

    // reset while waiting on memory; a late ack must be ignored
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 10 && !bus.mem_req; i++) step(0, 0);
    step(0, 0);
    rst_cmd = 1;
    step(0, 0);
    rst_cmd = 0; rbusy = 0; force_ack = 1;
    step(0, 0);
    reqlog.delete();
    vlog.delete();
    run_until_valid(1, 30);
    chk("rst_req_addr", qget(reqlog, 0), 32'h0);
    chk("rst_data", qget(vlog, 0), 32'h100);

    // random traffic: random latency, redirects (some near the wrap point), resets
    do_reset();
    lat_min = 0; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] pc;
      int r;
      rst_cmd = ($urandom_range(0, 199) == 0);
      r  = $urandom_range(0, 99);
      pc = m_exp;
      if (r < 3)      pc = $urandom & ~32'h3;
      else if (r < 5) pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else if (r < 7) pc = m_exp + 32'h8;
      step($urandom_range(0, 9) < 8, pc);
    end
    rst_cmd = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
